// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries with flush; pointers carry one extra wrap bit.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ibus master, prefetch queue and decode handshake.
// Optional FETCH_BYPASS_EN forwards bus data straight to decode when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] ibus_addr,
  input  logic [31:0] ibus_data,
  output logic        ibus_valid,
  input  logic        ibus_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(QUEUE_DEPTH);

  fetch_state_t state, state_next;
  logic [XLEN-1:0] pc;
  logic            fire;
  logic            push;
  logic            pop;
  fetch_entry_t    q_din;
  fetch_entry_t    q_dout;
  logic [AW:0]     q_count;
  logic            q_full;
  logic            q_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect)  pc <= redirect_pc & ~32'h3;
      else if (fire) pc <= pc + 32'd4;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:    state_next = FETCH;
      FETCH:   if (halt_req && !redirect) state_next = HALTED;
      HALTED:  if (redirect) state_next = FETCH;
      default: state_next = BOOT;
    endcase
  end

  assign ibus_addr  = pc;
  assign ibus_valid = (state == FETCH) && !halt_req && !redirect && (q_count < DEPTH_L);
  assign fire       = ibus_valid && ibus_ready;
  assign halted     = (state == HALTED);
  assign q_din      = '{pc: pc, instr: ibus_data};
  assign pop        = !q_empty && out_ready && !redirect;

  // Outputs read as zero when nothing is offered so stale queue storage never leaks.
  always_comb begin
    out_valid = !q_empty;
    out_pc    = '0;
    out_instr = '0;
    push      = fire && !q_full;
    if (!q_empty) begin
      out_pc    = q_dout.pc;
      out_instr = q_dout.instr;
    end
`ifdef FETCH_BYPASS_EN
    else if (fire) begin
      out_valid = 1'b1;
      out_pc    = pc;
      out_instr = ibus_data;
      push      = fire && !q_full && !out_ready;
    end
`endif
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule
